rr_grant_ctrl: RTL and testbench

RR_GRANT_CTRL -- requirements
Module: rr_grant_ctrl

---
 rtl/rr_grant_ctrl.sv | 123 ++++++++++++
 tb/tb_rr_grant_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin grant controller for one shared resource.
// Each grant is followed by a fixed busy phase and a one-cycle cool-down
// before requests are sampled again. All outputs are registered.
module rr_grant_ctrl #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned BUSY_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [CNT_W-1:0]        grant_cnt
);

    localparam int unsigned PTR_W  = $clog2(NREQ);
    localparam int unsigned BCNT_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_COOL  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_nxt;
    logic [NREQ-1:0]   gnt_nxt;
    logic              busy_nxt;
    logic [PTR_W-1:0]  owner_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    int unsigned       idx_sum;

    // Winner search: first set request at or above ptr, wrapping to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_sum   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx_sum = int'(ptr) + i;
            if (idx_sum >= NREQ) begin
                idx_sum = idx_sum - NREQ;
            end
            if (!win_found && req[PTR_W'(idx_sum)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx_sum);
            end
        end
    end

    // Next-state and next-output logic; req only matters in IDLE.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        bcnt_nxt  = bcnt;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        owner_nxt = owner;
        cnt_nxt   = grant_cnt;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt = S_GRANT;
                    gnt_nxt   = NREQ'(1) << win_idx;
                    owner_nxt = win_idx;
                    ptr_nxt   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
                    if (grant_cnt != '1) begin
                        cnt_nxt = grant_cnt + CNT_W'(1);
                    end
                end
            end
            S_GRANT: begin
                state_nxt = S_BUSY;
                busy_nxt  = 1'b1;
                bcnt_nxt  = BCNT_W'(BUSY_CYCLES);
            end
            S_BUSY: begin
                if (bcnt <= BCNT_W'(1)) begin
                    state_nxt = S_COOL;
                    bcnt_nxt  = '0;
                end else begin
                    busy_nxt = 1'b1;
                    bcnt_nxt = bcnt - BCNT_W'(1);
                end
            end
            S_COOL: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            bcnt      <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            owner     <= '0;
            grant_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            bcnt      <= bcnt_nxt;
            gnt       <= gnt_nxt;
            busy      <= busy_nxt;
            owner     <= owner_nxt;
            grant_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl (NREQ=4, BUSY_CYCLES=2), plus a
// CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_rr_grant_ctrl;

    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0]  gnt;
    logic        busy;
    logic [1:0]  owner;
    logic [15:0] grant_cnt;

    logic [3:0]  s_gnt;
    logic        s_busy;
    logic [1:0]  s_owner;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: cycles elapsed since the last grant decide the outputs.
    int m_phase = B + 2;
    int m_ptr   = 0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_cnt_s = 0;

    rr_grant_ctrl #(.NREQ(4), .BUSY_CYCLES(B), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt), .busy(busy), .owner(owner), .grant_cnt(grant_cnt)
    );

    rr_grant_ctrl #(.NREQ(4), .BUSY_CYCLES(B), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(s_gnt), .busy(s_busy), .owner(s_owner), .grant_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] exp_vec();
        logic [3:0] g;
        logic       b;
        g = 4'b0000;
        b = 1'b0;
        if (m_phase == 0) g = 4'(1) << m_owner;
        else if (m_phase <= B) b = 1'b1;
        return {g, b, 2'(m_owner), 16'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_phase = B + 2;
        m_ptr   = 0;
        m_owner = 0;
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    // Drive req, advance one clock edge, update the model, settle 1 time unit.
    task automatic tick(input logic [3:0] r);
        logic done;
        int   idx;
        req = r;
        @(posedge clk);
        if (rst_n) begin
            if (m_phase >= B + 2) begin
                done = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (!done && r[idx]) begin
                        done    = 1'b1;
                        m_owner = idx;
                        m_ptr   = (idx + 1) % 4;
                        m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                        m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : m_cnt_s;
                        m_phase = 0;
                    end
                end
            end else begin
                m_phase++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({gnt, busy, owner, grant_cnt} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_async: got %h expected 0", {gnt, busy, owner, grant_cnt});
        end
        tick(4'b1111);
        tick(4'b1111);
        n_checks++;
        if ({gnt, busy, owner, grant_cnt} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_held: got %h expected 0", {gnt, busy, owner, grant_cnt});
        end
        #2;
        model_reset();
        rst_n = 1'b1;
        tick(4'b0101);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_first_edge: gnt=%b expected 0001", gnt);
        end
    endtask

    task automatic test_single();
        logic [3:0] r;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            r = (c == 0) ? 4'b0001 : 4'b0000;
            tick(r);
            n_checks++;
            if ({gnt, busy, owner, grant_cnt} !== exp_vec()) begin
                n_err++;
                $display("FAIL single c%0d: got %h expected %h", c, {gnt, busy, owner, grant_cnt}, exp_vec());
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_own[5];
        int last_t;
        int ng;
        exp_own = '{0, 1, 2, 3, 0};
        last_t  = -1;
        ng      = 0;
        do_reset();
        for (int t = 1; t <= 21; t++) begin
            tick(4'b1111);
            n_checks++;
            if ({gnt, busy, owner, grant_cnt} !== exp_vec()) begin
                n_err++;
                $display("FAIL rr_model t%0d: got %h expected %h", t, {gnt, busy, owner, grant_cnt}, exp_vec());
            end
            if (gnt != 4'b0000 && ng < 5) begin
                n_checks++;
                if (int'(owner) != exp_own[ng] || (last_t >= 0 && t - last_t != B + 3)) begin
                    n_err++;
                    $display("FAIL rr_order #%0d: owner=%0d t=%0d expected owner=%0d spacing=%0d",
                             ng, owner, t, exp_own[ng], B + 3);
                end
                last_t = t;
                ng++;
            end
        end
        n_checks++;
        if (grant_cnt !== 16'd5 || ng != 5) begin
            n_err++;
            $display("FAIL rr_count: grant_cnt=%0d grants=%0d expected 5", grant_cnt, ng);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(4'b0100);
        for (int c = 0; c < 4; c++) tick(4'b0000);
        tick(4'b0101);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL wrap_first: gnt=%b expected 0001", gnt);
        end
        for (int c = 0; c < 5; c++) begin
            tick(4'b0101);
            n_checks++;
            if ({gnt, busy, owner, grant_cnt} !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap_model c%0d: got %h expected %h", c, {gnt, busy, owner, grant_cnt}, exp_vec());
            end
        end
        n_checks++;
        if (gnt !== 4'b0100 || owner !== 2'd2) begin
            n_err++;
            $display("FAIL wrap_second: gnt=%b owner=%0d expected 0100 owner=2", gnt, owner);
        end
    endtask

    task automatic test_ignored();
        logic seen2;
        seen2 = 1'b0;
        do_reset();
        tick(4'b0001);
        tick(4'b0000);
        tick(4'b0100);
        for (int c = 0; c < 10; c++) begin
            tick(4'b0000);
            if (gnt[2]) seen2 = 1'b1;
            n_checks++;
            if ({gnt, busy, owner, grant_cnt} !== exp_vec()) begin
                n_err++;
                $display("FAIL ignored_model c%0d: got %h expected %h", c, {gnt, busy, owner, grant_cnt}, exp_vec());
            end
        end
        n_checks++;
        if (seen2 || grant_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL ignored_req: seen_gnt2=%0d cnt=%0d expected 0 and 1", seen2, grant_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, busy, owner, grant_cnt} !== 23'd0) begin
            n_err++;
            $display("FAIL abort_grant: got %h expected 0", {gnt, busy, owner, grant_cnt});
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        tick(4'b0001);
        tick(4'b0000);
        n_checks++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_before_abort: busy=%b expected 1", busy);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, busy, owner, grant_cnt} !== 23'd0) begin
            n_err++;
            $display("FAIL abort_busy: got %h expected 0", {gnt, busy, owner, grant_cnt});
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        tick(4'b1000);
        n_checks++;
        if (gnt !== 4'b1000 || owner !== 2'd3 || grant_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL after_release: gnt=%b owner=%0d cnt=%0d expected 1000 3 1", gnt, owner, grant_cnt);
        end
        for (int c = 0; c < 5; c++) begin
            tick(4'b0000);
            n_checks++;
            if ({gnt, busy, owner, grant_cnt} !== exp_vec()) begin
                n_err++;
                $display("FAIL release_model c%0d: got %h expected %h", c, {gnt, busy, owner, grant_cnt}, exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        int seq[5];
        int ng;
        seq = '{1, 2, 3, 3, 3};
        ng  = 0;
        do_reset();
        for (int t = 1; t <= 23; t++) begin
            tick(4'b1111);
            n_checks++;
            if (s_cnt !== 2'(m_cnt_s) || s_gnt !== gnt || s_busy !== busy) begin
                n_err++;
                $display("FAIL sat_model t%0d: cnt=%0d gnt=%b busy=%b expected cnt=%0d gnt=%b busy=%b",
                         t, s_cnt, s_gnt, s_busy, m_cnt_s, gnt, busy);
            end
            if (s_gnt != 4'b0000 && ng < 5) begin
                n_checks++;
                if (int'(s_cnt) != seq[ng]) begin
                    n_err++;
                    $display("FAIL sat_seq #%0d: cnt=%0d expected %0d", ng, s_cnt, seq[ng]);
                end
                ng++;
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       prev_busy;
        prev_busy = 1'b0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            tick(r);
            n_checks++;
            if ({gnt, busy, owner, grant_cnt} !== exp_vec()) begin
                n_err++;
                $display("FAIL random_model c%0d: got %h expected %h", c, {gnt, busy, owner, grant_cnt}, exp_vec());
            end
            n_checks++;
            if (!$onehot0(gnt) || (gnt != 4'b0000 && busy) || (prev_busy && !busy && gnt != 4'b0000)) begin
                n_err++;
                $display("FAIL random_invariant c%0d: gnt=%b busy=%b prev_busy=%b", c, gnt, busy, prev_busy);
            end
            prev_busy = busy;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_ignored();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
